dmem_responder: RTL and testbench

- Data-memory responder at the far end of the memory stage's `mem_read_req` / `mem_write_req` interface.
- Accepts one load or store per transaction and models a fixed-latency word-addressed RAM.
- Commits stores with byte strobes derived from address and size, and returns the raw aligned word on `rd`.
- Holds the pipeline through `stall` (to hazard unit) until the response cycle.

---
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request bus between the memory stage and the data-memory responder.
// Revision 1.0 - initial release.
`default_nettype none

interface dmem_responder_if;
  logic        mread_valid;
  logic [31:0] mread_addr;
  logic [1:0]  mread_size;
  logic        mwrite_valid;
  logic [31:0] mwrite_addr;
  logic [31:0] mwrite_data;
  logic [1:0]  mwrite_size;
  logic [31:0] rd;
  logic        stall;
  logic        err;

  modport master (
    output mread_valid, mread_addr, mread_size,
    output mwrite_valid, mwrite_addr, mwrite_data, mwrite_size,
    input  rd, stall, err
  );

  modport slave (
    input  mread_valid, mread_addr, mread_size,
    input  mwrite_valid, mwrite_addr, mwrite_data, mwrite_size,
    output rd, stall, err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word-addressed data RAM with byte strobes, stall and fault pulse.
// Revision 1.0 - initial release.
`default_nettype none

module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  dmem_responder_if.slave  bus
);

  localparam int         c_AW     = $clog2(DEPTH);
  localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic            r_is_wr;
  logic            r_drop;
  logic [c_AW+1:0] r_addr;
  logic [31:0]     r_data;
  logic [1:0]      r_size;
  logic [31:0]     r_rd;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req;
  logic            w_latch;
  logic            w_stall;
  logic            w_resp;
  logic            w_fault;
  logic [3:0]      w_strb;
  logic            w_commit;
  logic [31:0]     w_word;
  logic [31:0]     w_load_val;
  logic            w_unused;

  // Address bits above the array span only alias, so they are dropped at latch time.
  assign w_unused = &{1'b0, bus.mread_addr[31:c_AW+2], bus.mwrite_addr[31:c_AW+2]};

  assign w_req      = bus.mread_valid | bus.mwrite_valid;
  assign w_resp     = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_word     = r_mem[r_addr[c_AW+1:2]];
  assign w_load_val = w_fault ? 32'd0 : w_word;
  assign w_commit   = w_resp & r_is_wr & ~w_fault;

  always_comb begin
    w_strb  = 4'b0000;
    w_fault = 1'b0;
    case (r_size)
      2'd0: w_strb = 4'b0001 << r_addr[1:0];
      2'd1: begin
        w_strb  = r_addr[1] ? 4'b1100 : 4'b0011;
        w_fault = r_addr[0];
      end
      2'd2: begin
        w_strb  = 4'b1111;
        w_fault = |r_addr[1:0];
      end
      default: w_fault = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_latch     = 1'b1;
          w_stall     = 1'b1;
          w_cnt_nxt   = c_LAT_M1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_is_wr <= 1'b0;
      r_drop  <= 1'b0;
      r_addr  <= '0;
      r_data  <= 32'd0;
      r_size  <= 2'd0;
      r_rd    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_is_wr <= bus.mwrite_valid;
        r_drop  <= bus.mwrite_valid & bus.mread_valid;
        r_addr  <= bus.mwrite_valid ? bus.mwrite_addr[c_AW+1:0] : bus.mread_addr[c_AW+1:0];
        r_size  <= bus.mwrite_valid ? bus.mwrite_size : bus.mread_size;
        r_data  <= bus.mwrite_data;
      end
      if (w_resp && !r_is_wr) begin
        r_rd <= w_load_val;
      end
    end
  end

  // Array is deliberately unreset; an aborted transaction never reaches w_commit.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) begin
          r_mem[r_addr[c_AW+1:2]][8*b +: 8] <= r_data[8*b +: 8];
        end
      end
    end
  end

  assign bus.stall = w_stall;
  assign bus.err   = w_resp & (w_fault | r_drop);
  assign bus.rd    = (w_resp && !r_is_wr) ? w_load_val : r_rd;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with a byte-level reference memory.
// Revision 1.0 - initial release.
`default_nettype none

module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       nm;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] act;
    logic [31:0] exp;
  } dchk_t;

  exp_t        q[$];
  dchk_t       dq[$];
  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b1;
  int          run      = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rd   = 32'd0;
  int          pool [20];

  // Reference: a request touches (1<<size) bytes starting at addr[1:0]; misaligned or size 3 faults.
  function automatic void model(input bit rv, input bit wv, input logic [31:0] a,
                                input logic [31:0] d, input logic [1:0] sz, input string nm);
    exp_t e;
    int   off = int'(a[1:0]);
    int   nb  = 1 << sz;
    int   idx = int'((a >> 2) % DEPTH);
    bit   f   = (sz == 2'd3) || ((off % nb) != 0);
    e.nm = nm;
    if (wv) begin
      if (!f) begin
        for (int b = 0; b < 4; b++) begin
          if (b >= off && b < off + nb) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
      end
      e.rd  = ref_rd;
      e.err = f || rv;
    end else begin
      e.rd   = f ? 32'd0 : ref_mem[idx];
      ref_rd = e.rd;
      e.err  = f;
    end
    q.push_back(e);
  endfunction

  function automatic void dcheck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    dchk_t c;
    c.nm  = nm;
    c.act = act;
    c.exp = exp;
    dq.push_back(c);
  endfunction

  // Called at posedge+1; leaves the request asserted at posedge+1 after its response cycle.
  task automatic req(input bit rv, input bit wv, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input string nm);
    int n = 0;
    model(rv, wv, a, d, sz, nm);
    bus.mread_valid  = rv;
    bus.mwrite_valid = wv;
    bus.mread_addr   = a;
    bus.mwrite_addr  = a;
    bus.mwrite_data  = d;
    bus.mread_size   = sz;
    bus.mwrite_size  = sz;
    do begin
      @(negedge clk);
      n++;
    end while (bus.stall && n < 20);
    if (bus.stall) dcheck({"timeout_", nm}, 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus(input int cycles);
    bus.mread_valid  = 1'b0;
    bus.mwrite_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Monitor: a cycle with a request present and stall low is a response cycle.
  always @(negedge clk) begin
    exp_t  e;
    dchk_t c;
    while (dq.size() > 0) begin
      c = dq.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", c.nm, c.act, c.exp);
      end
    end
    if (!mon_en) begin
      run = 0;
    end else if ((bus.mread_valid || bus.mwrite_valid) && !bus.stall) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_response: rd=%h err=%b with empty scoreboard", bus.rd, bus.err);
      end else begin
        e = q.pop_front();
        checks += 3;
        if (bus.rd !== e.rd) begin
          failures++;
          $display("FAIL %s rd: got %h expected %h", e.nm, bus.rd, e.rd);
        end
        if (bus.err !== e.err) begin
          failures++;
          $display("FAIL %s err: got %b expected %b", e.nm, bus.err, e.err);
        end
        if (run != LAT) begin
          failures++;
          $display("FAIL %s latency: stall cycles %0d expected %0d", e.nm, run, LAT);
        end
      end
      run = 0;
    end else begin
      if (bus.stall) run++;
      checks++;
      if (bus.err !== 1'b0) begin
        failures++;
        $display("FAIL err_idle: got %b expected 0", bus.err);
      end
    end
  end

  initial begin
    logic [31:0] a1   [4];
    logic [31:0] d1   [4];
    bit          w1   [4];
    logic [31:0] rexp;
    logic [31:0] r;
    int          idx;

    bus.mread_valid  = 1'b0;
    bus.mwrite_valid = 1'b0;
    bus.mread_addr   = 32'd0;
    bus.mwrite_addr  = 32'd0;
    bus.mwrite_data  = 32'd0;
    bus.mread_size   = 2'd0;
    bus.mwrite_size  = 2'd0;
    bus1.mread_valid  = 1'b0;
    bus1.mwrite_valid = 1'b0;
    bus1.mread_addr   = 32'd0;
    bus1.mwrite_addr  = 32'd0;
    bus1.mwrite_data  = 32'd0;
    bus1.mread_size   = 2'd2;
    bus1.mwrite_size  = 2'd2;

    @(negedge clk);
    dcheck("rst_stall", {31'd0, bus.stall}, 32'd0);
    dcheck("rst_err", {31'd0, bus.err}, 32'd0);
    dcheck("rst_rd", bus.rd, 32'd0);
    dcheck("rst_rd_l1", bus1.rd, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) pool[i] = (i < 16) ? i : 48 + i;
    for (int i = 0; i < 20; i++) req(1'b0, 1'b1, 32'(pool[i] * 4), $urandom(), 2'd2, "init");

    req(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2'd2, "st_deadbeef");
    req(1'b1, 1'b0, 32'h100, 32'd0, 2'd2, "ld_deadbeef");
    idle_bus(1);

    // Store aborted by reset while still counting down.
    mon_en           = 1'b0;
    bus.mwrite_valid = 1'b1;
    bus.mwrite_addr  = 32'h100;
    bus.mwrite_data  = 32'h12345678;
    bus.mwrite_size  = 2'd2;
    @(posedge clk);
    #1;
    resetn           = 1'b0;
    bus.mwrite_valid = 1'b0;
    @(negedge clk);
    dcheck("abort_stall", {31'd0, bus.stall}, 32'd0);
    dcheck("abort_rd", bus.rd, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    ref_rd = 32'd0;
    @(negedge clk);
    dcheck("post_rst_stall", {31'd0, bus.stall}, 32'd0);
    dcheck("post_rst_err", {31'd0, bus.err}, 32'd0);
    dcheck("post_rst_rd", bus.rd, 32'd0);
    @(posedge clk);
    #1 mon_en = 1'b1;
    req(1'b1, 1'b0, 32'h100, 32'd0, 2'd2, "ld_after_abort");

    req(1'b0, 1'b1, 32'h104, 32'h11223344, 2'd2, "st_11223344");
    req(1'b0, 1'b1, 32'h106, 32'h00AA0000, 2'd0, "st_byte106");
    req(1'b0, 1'b1, 32'h104, 32'h0000BEEF, 2'd1, "st_half104");
    req(1'b1, 1'b0, 32'h104, 32'd0, 2'd2, "ld_11aabeef");
    req(1'b0, 1'b1, 32'h102, 32'hFFFFFFFF, 2'd2, "st_misalign");
    req(1'b1, 1'b0, 32'h100, 32'd0, 2'd2, "ld_unchanged");
    req(1'b1, 1'b0, 32'h103, 32'd0, 2'd1, "ld_half_misalign");
    req(1'b1, 1'b0, 32'h100, 32'd0, 2'd3, "ld_size3");
    req(1'b0, 1'b1, 32'h100, 32'd0, 2'd3, "st_size3");
    req(1'b1, 1'b1, 32'h8, 32'h55, 2'd2, "both_valid");
    req(1'b1, 1'b0, 32'h8, 32'd0, 2'd2, "ld_both");
    req(1'b0, 1'b1, 32'h1000, 32'hA0A0A0A0, 2'd2, "st_wrap");
    req(1'b1, 1'b0, 32'h0, 32'd0, 2'd2, "ld_wrap");
    idle_bus(2);

    for (int i = 0; i < 200; i++) begin
      int          k;
      logic [31:0] a;
      logic [1:0]  sz;
      idx = pool[$urandom_range(0, 19)];
      a   = ($urandom() & 32'hFFFF_F000) | 32'(idx * 4) | 32'($urandom_range(0, 3));
      sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      k   = $urandom_range(0, 9);
      if (k < 4)       req(1'b1, 1'b0, a, $urandom(), sz, "rnd_ld");
      else if (k == 8) req(1'b1, 1'b1, a, $urandom(), sz, "rnd_both");
      else             req(1'b0, 1'b1, a, $urandom(), sz, "rnd_st");
      if ($urandom_range(0, 3) == 0) idle_bus($urandom_range(1, 3));
    end
    idle_bus(2);

    // LATENCY=1 instance: two stores then two loads, each occupying exactly two cycles.
    a1[0] = 32'hC;  d1[0] = 32'hCAFE0003; w1[0] = 1'b1;
    a1[1] = 32'h10; d1[1] = 32'hBEEF0004; w1[1] = 1'b1;
    a1[2] = 32'hC;  d1[2] = 32'd0;        w1[2] = 1'b0;
    a1[3] = 32'h10; d1[3] = 32'd0;        w1[3] = 1'b0;
    rexp = 32'd0;
    for (int i = 0; i < 4; i++) begin
      bus1.mwrite_valid = w1[i];
      bus1.mread_valid  = !w1[i];
      bus1.mwrite_addr  = a1[i];
      bus1.mread_addr   = a1[i];
      bus1.mwrite_data  = d1[i];
      @(negedge clk);
      dcheck("l1_stall_accept", {31'd0, bus1.stall}, 32'd1);
      dcheck("l1_err_accept", {31'd0, bus1.err}, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      if (!w1[i]) rexp = (i == 2) ? 32'hCAFE0003 : 32'hBEEF0004;
      r = bus1.rd;
      dcheck("l1_stall_resp", {31'd0, bus1.stall}, 32'd0);
      dcheck("l1_err_resp", {31'd0, bus1.err}, 32'd0);
      dcheck("l1_rd_resp", r, rexp);
      @(posedge clk);
      #1;
    end
    bus1.mwrite_valid = 1'b0;
    bus1.mread_valid  = 1'b0;
    @(negedge clk);
    dcheck("l1_idle_stall", {31'd0, bus1.stall}, 32'd0);
    dcheck("l1_rd_hold", bus1.rd, 32'hBEEF0004);

    dcheck("sb_empty", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
